// File: rtl/lcd_text_arbiter.sv
// Round-robin arbiter sharing one lcd_init text channel among NUM_REQ clients.
// Optional WAIT watchdog enabled by defining LCD_TEXT_ARBITER_TIMEOUT_EN.
`timescale 1ns/1ps

module lcd_text_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TEXT_BYTES     = 34,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ*8*TEXT_BYTES-1:0] text_in,
  output logic [NUM_REQ-1:0]              grant,
  output logic [NUM_REQ-1:0]              done,
  output logic                            busy,
  output logic                            lcd_send_text,
  output logic [8*TEXT_BYTES-1:0]         lcd_text,
  input  logic                            lcd_sending_done,
  output logic                            timeout_err
);

  localparam int unsigned TextW = 8 * TEXT_BYTES;
  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("NUM_REQ must be in 2..4");
  end
  if (GAP_CYCLES < 1 || TEXT_BYTES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("GAP_CYCLES, TEXT_BYTES and TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {StIdle, StLatch, StSend, StWait, StDone, StGap} state_e;

  state_e             state_q, state_d;
  logic [IdxW-1:0]    win_q, win_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               send_q, send_d;
  logic [TextW-1:0]   text_q, text_d;
  logic               prev_sd_q, prev_sd_d;
  logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
  logic               to_err_q, to_err_d;
  logic [IdxW-1:0]    pick;
  logic               found;

`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic           to_hit_q, to_hit_d;
`endif

  // First requester at or after rr, wrapping modulo NUM_REQ.
  always_comb begin
    pick  = rr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned idx;
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IdxW'(idx)]) begin
        found = 1'b1;
        pick  = IdxW'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    done_d    = '0;
    send_d    = 1'b0;
    text_d    = text_q;
    prev_sd_d = prev_sd_q;
    gap_cnt_d = gap_cnt_q;
    to_err_d  = 1'b0;
`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    to_hit_d  = to_hit_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          win_d   = pick;
          state_d = StLatch;
        end
      end
      StLatch: begin
        grant_d        = '0;
        grant_d[win_q] = 1'b1;
        text_d         = text_in[int'(win_q)*TextW +: TextW];
        state_d        = StSend;
      end
      StSend: begin
        send_d    = 1'b1;
        // sendingDone may still be high from lcd_init's init phase; only a fresh rise counts.
        prev_sd_d = 1'b1;
        state_d   = StWait;
`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
        to_cnt_d  = '0;
        to_hit_d  = 1'b0;
`endif
      end
      StWait: begin
        prev_sd_d = lcd_sending_done;
        if (lcd_sending_done && !prev_sd_q) begin
          state_d = StDone;
`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
        end else if (to_cnt_q == ToW'(TIMEOUT_CYCLES)) begin
          state_d  = StDone;
          to_hit_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
`endif
        end
      end
      StDone: begin
        done_d        = '0;
        done_d[win_q] = 1'b1;
        grant_d       = '0;
        rr_d          = (int'(win_q) == NUM_REQ - 1) ? '0 : win_q + 1'b1;
        gap_cnt_d     = '0;
`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
        to_err_d      = to_hit_q;
`endif
        state_d       = StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      win_q     <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      send_q    <= 1'b0;
      text_q    <= '0;
      prev_sd_q <= 1'b1;
      gap_cnt_q <= '0;
      to_err_q  <= 1'b0;
`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
      to_cnt_q  <= '0;
      to_hit_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      send_q    <= send_d;
      text_q    <= text_d;
      prev_sd_q <= prev_sd_d;
      gap_cnt_q <= gap_cnt_d;
      to_err_q  <= to_err_d;
`ifdef LCD_TEXT_ARBITER_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      to_hit_q  <= to_hit_d;
`endif
    end
  end

  assign grant         = grant_q;
  assign done          = done_q;
  assign busy          = (state_q != StIdle);
  assign lcd_send_text = send_q;
  assign lcd_text      = text_q;
  assign timeout_err   = to_err_q;

endmodule

// File: doc/lcd_text_arbiter.md
# lcd_text_arbiter

- Round-robin arbiter that lets NUM_REQ independent clients share one `lcd_init` text channel.
- Selects one requester and latches its text into a holding register.
- Issues a single-cycle `sendText` pulse to `lcd_init`, waits for its completion flag, then returns a done pulse to the owner.
- Sits between application logic (status, menu and debug text sources) and `lcd_init`.

## Interface

Parameters:
- NUM_REQ, 2: number of requesters, legal range 2..4.
- TEXT_BYTES, 34: characters per message; must equal the `lcd_init` text length.
- GAP_CYCLES, 16: idle guard cycles between consecutive transfers, minimum 1.
- TIMEOUT_CYCLES, 1000000: WAIT watchdog limit (20 ms at 50 MHz); used only with the macro.

Ports:
- CLK  in  1  system clock, 50 MHz.
- RST  in  1  reset; asynchronous, active-high.
- req  in  NUM_REQ  level request, one bit per client.
- text_in  in  NUM_REQ*8*TEXT_BYTES  concatenated client texts; client i occupies slice i.
- grant  out  NUM_REQ  one-hot owner indication, held for the whole transfer.
- done  out  NUM_REQ  one-cycle completion pulse to the owner.
- busy  out  1  high in any state other than IDLE.
- lcd_send_text  out  1  one-cycle pulse to `lcd_init` sendText.
- lcd_text  out  8*TEXT_BYTES  latched text to `lcd_init`, stable from grant until the next latch.
- lcd_sending_done  in  1  `lcd_init` sendingDone (sticky level).
- timeout_err  out  1  one-cycle pulse on watchdog expiry; constant 0 without the macro.

## Operation

- States: IDLE -> LATCH -> SEND -> WAIT -> DONE -> GAP -> IDLE.
- IDLE:
  - If any req bit is high, choose the winner by round-robin from pointer `rr`: search rr, rr+1, … modulo NUM_REQ.
  - Register the winner index and go to LATCH.
- LATCH:
  - Assert grant[winner].
  - Copy the winner's slice of text_in into lcd_text.
  - Go to SEND.
- SEND:
  - Assert lcd_send_text for exactly this cycle.
  - Load `prev_sd` with 1.
  - Go to WAIT.
- WAIT:
  - `prev_sd` <= lcd_sending_done every cycle.
  - Completion is the rising edge `lcd_sending_done & ~prev_sd`.
  - `lcd_init` holds sendingDone high through its init phase and drops it after the first text nibble, so a level that is already high is not completion.
  - On the edge, go to DONE.
- DONE:
  - Pulse done[winner].
  - Drop grant.
  - `rr` <= winner+1 modulo NUM_REQ.
  - Go to GAP.
- GAP:
  - Count GAP_CYCLES cycles, then go to IDLE.
  - req is ignored during GAP.
- Request rules:
  - Deasserting req after LATCH does not abort the transfer; done still pulses.
  - A client that holds req after done is re-arbitrated behind the other active clients.
- text_in of the winner is sampled only at the LATCH edge; clients may change it afterwards.

## Timing

- Reset values:
  - grant, done, lcd_send_text, timeout_err, busy = 0.
  - lcd_text = all zero.
  - rr = 0; state = IDLE; prev_sd = 1.
- Request to grant:
  - req seen high at edge N (IDLE) -> grant high and lcd_text valid after edge N+1.
  - lcd_send_text high after edge N+2 for one cycle.
- Completion:
  - lcd_sending_done rising edge sampled at edge M -> done pulse after edge M+1; grant low in the same cycle.
  - The next grant comes no earlier than M+1+GAP_CYCLES+2.
- Simultaneous requests: exactly one grant per transfer, never two bits at once.
- RST mid-transfer:
  - All outputs go to reset values immediately; no done pulse.
  - `lcd_init` is not reset and may finish. Its completion edge lands in IDLE or GAP and is ignored, because edge detection is armed only in WAIT.

## Configuration

- Macro: LCD_TEXT_ARBITER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears in SEND and counts in WAIT.
  - On reaching TIMEOUT_CYCLES: pulse timeout_err and done[winner] together, advance rr, go to GAP.
- Undefined:
  - No counter; WAIT lasts indefinitely.
  - timeout_err is tied to 0.

## Test plan

- Single client:
  - Stimulus: NUM_REQ=2; req=01 with text "HELLO…"; model raises sendingDone 500 cycles after the send pulse.
  - Required: grant=01 one cycle after req; lcd_text equals the slice; one send pulse; done=01 two cycles after the edge; busy back to 0 after 16 gap cycles.
- Contention:
  - Stimulus: req=11 held through three transfers.
  - Required: grant order 01, 10, 01; done pulses match; grant never 11.
- Stale level:
  - Stimulus: lcd_sending_done held high from before the send, dropped at cycle 100, raised at cycle 300.
  - Required: done only after the cycle-300 edge, not on entry to WAIT.
- Request drop and text change:
  - Stimulus: client 1 drops req and changes text_in 2 cycles after grant.
  - Required: transfer completes; done=10; lcd_text keeps the original text.
- Reset mid-WAIT:
  - Stimulus: RST pulsed during WAIT; sendingDone edge arrives 50 cycles later.
  - Required: all outputs 0 at once; no done; the edge is ignored; a fresh req is served normally.
- Timeout (macro defined):
  - Stimulus: TIMEOUT_CYCLES=1000; sendingDone never rises.
  - Required: timeout_err and done[winner] pulse 1000 cycles after SEND, then GAP and IDLE.
